pwm_ramp_ctrl: RTL and testbench

Sequencer that drives the period/duty inputs of the team's PWM generator. It accepts a new target (period, duty, step size, frames-per-step) over a valid/ready handshake. The new period is applied at the next frame boundary. Duty then ramps toward the target in fixed steps, only at frame boundaries, for glitch-free soft-start and soft-stop of motor and LED loads. It sits between the register/config layer and the PWM instance; its outputs wire directly to that instance's period and duty inputs.

---
 rtl/pwm_ramp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// PWM period/duty sequencer: applies new periods and ramps duty only at frame boundaries.
// Optional build macro DUTY_CLAMP_EN clamps the accepted duty target to the new period.
module pwm_ramp_ctrl #(
    parameter int          W            = 8,
    parameter int          DIV_W        = 8,
    parameter int unsigned RESET_PERIOD = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [W-1:0]     cfg_period,
    input  logic [W-1:0]     cfg_duty,
    input  logic [W-1:0]     cfg_step,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             stop,
    output logic [W-1:0]     period_out,
    output logic [W-1:0]     duty_out,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_RAMP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_frame_cnt;
    logic [W-1:0]     r_period;
    logic [W-1:0]     r_duty;
    logic [W-1:0]     r_pend_period;
    logic [W-1:0]     r_target;
    logic [W-1:0]     r_step;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_frame_start;
    logic             r_done;

    logic [W-1:0]     w_period_nxt;
    logic [W-1:0]     w_duty_nxt;
    logic [DIV_W-1:0] w_div_cnt_nxt;
    logic             w_done_nxt;
    logic             w_boundary;
    logic             w_accept;
    logic [W-1:0]     w_step_eff;
    logic [DIV_W-1:0] w_div_eff;
    logic [W-1:0]     w_target_in;
    logic [W-1:0]     w_stepped;

    // >= rather than == so a period shrinking below the running count still wraps.
    assign w_boundary = (r_frame_cnt >= r_period);
    assign w_accept   = cfg_valid && (r_state == S_IDLE);
    assign w_step_eff = (cfg_step == '0) ? W'(1) : cfg_step;
    assign w_div_eff  = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

`ifdef DUTY_CLAMP_EN
    assign w_target_in = (cfg_duty > cfg_period) ? cfg_period : cfg_duty;
`else
    assign w_target_in = cfg_duty;
`endif

    // Saturating step toward the target using differences, so no wrap can occur.
    always_comb begin
        w_stepped = r_target;
        if (r_duty < r_target) begin
            if ((r_target - r_duty) > r_step) w_stepped = r_duty + r_step;
        end else if (r_duty > r_target) begin
            if ((r_duty - r_target) > r_step) w_stepped = r_duty - r_step;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no latch is inferred.
        w_state_nxt   = r_state;
        w_period_nxt  = r_period;
        w_duty_nxt    = r_duty;
        w_div_cnt_nxt = r_div_cnt;
        w_done_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cfg_valid) w_state_nxt = S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_boundary) begin
                    w_period_nxt  = r_pend_period;
                    w_div_cnt_nxt = '0;
                    if (r_duty == r_target) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RAMP;
                    end
                end
            end
            S_RAMP: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_boundary) begin
                    if (r_div_cnt == r_div - DIV_W'(1)) begin
                        w_div_cnt_nxt = '0;
                        w_duty_nxt    = w_stepped;
                        if (w_stepped == r_target) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
            r_period      <= W'(RESET_PERIOD);
            r_duty        <= '0;
            r_div_cnt     <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_cnt   <= w_boundary ? '0 : r_frame_cnt + W'(1);
            r_frame_start <= w_boundary;
            r_period      <= w_period_nxt;
            r_duty        <= w_duty_nxt;
            r_div_cnt     <= w_div_cnt_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // NOTE: pending registers are reset too, so the first WAIT_FRAME never sees X values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_period <= W'(RESET_PERIOD);
            r_target      <= '0;
            r_step        <= W'(1);
            r_div         <= DIV_W'(1);
        end else if (w_accept) begin
            r_pend_period <= cfg_period;
            r_target      <= w_target_in;
            r_step        <= w_step_eff;
            r_div         <= w_div_eff;
        end
    end

    assign cfg_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign period_out  = r_period;
    assign duty_out    = r_duty;
    assign frame_start = r_frame_start;
    assign done        = r_done;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: table of ramp scenarios plus stop, clamp/busy and reset sequences.
// Expected duty steps are queued on acceptance and popped whenever duty_out changes.
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_duty = '0;
    logic [7:0] cfg_step = '0;
    logic [7:0] cfg_div = '0;
    logic       stop = 1'b0;
    logic [7:0] period_out;
    logic [7:0] duty_out;
    logic       frame_start;
    logic       busy;
    logic       done;

    pwm_ramp_ctrl #(.W(8), .DIV_W(8), .RESET_PERIOD(255)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_step    (cfg_step),
        .cfg_div     (cfg_div),
        .stop        (stop),
        .period_out  (period_out),
        .duty_out    (duty_out),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

`ifdef DUTY_CLAMP_EN
    localparam int CLAMP_FINAL = 50;
`else
    localparam int CLAMP_FINAL = 80;
`endif

    typedef struct {
        logic [7:0] duty;
        logic       done;
        int         gap;
    } exp_t;

    typedef struct {
        int              p, d, s, v, n, gap;
        logic [3:0][7:0] seq;
    } vec_t;

    exp_t       ex_q[$];
    vec_t       tbl[5];
    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_chg = 0;
    int         done_cnt = 0;
    logic [7:0] prev_duty = '0;
    bit         mon_en = 1'b0;

    function automatic vec_t mk(input int p, d, s, v, n, gap, s0, s1, s2, s3);
        vec_t r;
        r.p = p; r.d = d; r.s = s; r.v = v; r.n = n; r.gap = gap;
        r.seq[0] = 8'(s0); r.seq[1] = 8'(s1); r.seq[2] = 8'(s2); r.seq[3] = 8'(s3);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input bit dn, input int gap);
        exp_t e;
        e.duty = 8'(d); e.done = dn; e.gap = gap;
        ex_q.push_back(e);
    endtask

    // One clock: sample at the falling edge and score any duty_out change against the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (done) done_cnt++;
        if (mon_en && duty_out !== prev_duty) begin
            if (ex_q.size() == 0) begin
                check("unexpected_duty_change", duty_out, prev_duty);
            end else begin
                e = ex_q.pop_front();
                check("step_duty", duty_out, e.duty);
                check("step_done", done, e.done);
                check("step_on_frame_start", frame_start, 1);
                if (e.gap != 0) check("step_gap", cyc - last_chg, e.gap);
            end
            last_chg = cyc;
        end
        prev_duty = duty_out;
    endtask

    task automatic send_cfg(input int p, d, s, v);
        cfg_period = 8'(p); cfg_duty = 8'(d); cfg_step = 8'(s); cfg_div = 8'(v);
        cfg_valid  = 1'b1;
        check("cfg_ready_at_offer", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    // Waits for the boundary that applies the pending period; the step gaps are timed from it.
    task automatic wait_apply(input int p);
        int k;
        k = 0;
        tick();
        while (!frame_start && k < 600) begin tick(); k++; end
        check("frame_start_seen", frame_start, 1);
        check("period_applied", period_out, p);
        last_chg = cyc;
    endtask

    task automatic wait_duty(input int val, input int budget);
        int k;
        k = 0;
        while (duty_out !== 8'(val) && k < budget) begin tick(); k++; end
        check("reach_duty", duty_out, val);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy !== 1'b0 || ex_q.size() != 0) && k < budget) begin tick(); k++; end
        check("idle_reached", busy, 0);
        check("queue_drained", ex_q.size(), 0);
    endtask

    initial begin
        int  dc0;
        int  n;
        bit  held;

        //           period duty step div  n  gap   seq
        tbl[0] = mk(99, 40, 10, 2, 4, 200, 10, 20, 30, 40);
        tbl[1] = mk(99,  5, 15, 1, 3, 100, 25, 10,  5,  0);
        tbl[2] = mk( 9,  0,  5, 1, 1,  10,  0,  0,  0,  0);
        tbl[3] = mk( 9,  3,  0, 0, 3,  10,  1,  2,  3,  0);
        tbl[4] = mk( 9,  0,  3, 1, 1,  10,  0,  0,  0,  0);

        repeat (3) tick();
        check("rst_period", period_out, 255);
        check("rst_duty", duty_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_done", done, 0);
        check("rst_frame_start", frame_start, 0);
        rst_n     = 1'b1;
        prev_duty = duty_out;
        mon_en    = 1'b1;

        for (int i = 0; i < 5; i++) begin
            dc0 = done_cnt;
            for (int k = 0; k < tbl[i].n; k++) push(tbl[i].seq[k], k == tbl[i].n - 1, tbl[i].gap);
            send_cfg(tbl[i].p, tbl[i].d, tbl[i].s, tbl[i].v);
            wait_apply(tbl[i].p);
            wait_idle(2000);
            check("vec_done_once", done_cnt - dc0, 1);
            check("vec_final_duty", duty_out, tbl[i].seq[tbl[i].n - 1]);
        end

        // Stop mid-ramp at 20 while heading for 40: duty holds, no done, ready at once.
        dc0 = done_cnt;
        push(10, 0, 100);
        push(20, 0, 100);
        send_cfg(99, 40, 10, 1);
        wait_apply(99);
        wait_duty(20, 1000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy_low", busy, 0);
        check("stop_ready_high", cfg_ready, 1);
        held = 1'b1;
        repeat (350) begin
            tick();
            if (duty_out !== 8'd20) held = 1'b0;
        end
        check("stop_duty_held", held, 1);
        check("stop_no_done", done_cnt - dc0, 0);

        // Clamp behaviour and rejection of a config offered while busy.
        dc0 = done_cnt;
        push(40, 0, 51);
        if (CLAMP_FINAL == 50) begin
            push(50, 1, 51);
        end else begin
            push(60, 0, 51);
            push(80, 1, 51);
        end
        send_cfg(50, 80, 20, 1);
        wait_apply(50);
        wait_duty(40, 200);
        cfg_period = 8'd9; cfg_duty = 8'd0; cfg_step = 8'd1; cfg_div = 8'd0;
        cfg_valid  = 1'b1;
        check("busy_offer_not_ready", cfg_ready, 0);
        tick();
        cfg_valid = 1'b0;
        check("busy_offer_still_busy", busy, 1);
        wait_idle(1000);
        check("clamp_final_duty", duty_out, CLAMP_FINAL);
        check("reject_period_kept", period_out, 50);
        check("clamp_done_once", done_cnt - dc0, 1);

        // Ramp down and reset asynchronously as duty_out reaches 20.
        for (int d = CLAMP_FINAL - 10; d >= 20; d -= 10) push(d, 0, 100);
        send_cfg(99, 0, 10, 1);
        wait_apply(99);
        wait_duty(20, 1000);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_period", period_out, 255);
        check("arst_duty", duty_out, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", cfg_ready, 1);
        check("arst_done", done, 0);
        check("arst_queue_empty", ex_q.size(), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (frame_start) break;
        end
        check("first_frame_after_release", n, 256);
        check("post_rst_period", period_out, 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
